// File: rtl/regfile_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_access_arbiter_if
//
// Request/response bundle between one requester and the register-file
// arbiter. One instance per requester.
//
// Signals
//   req_valid  requester -> arbiter  request present
//   req_ready  arbiter -> requester  request accepted when valid & ready
//   req_we     requester -> arbiter  1 = write, 0 = read
//   req_lock   requester -> arbiter  keep the grant for the next cycle
//   req_addr   requester -> arbiter  register index
//   req_wdata  requester -> arbiter  write data
//   rsp_valid  arbiter -> requester  one-cycle response pulse
//   rsp_rdata  arbiter -> requester  register value at accept time
//
// Modports
//   master  the requester side
//   slave   the arbiter side
// ---------------------------------------------------------------------------
interface regfile_access_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_lock;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_access_arbiter
//
// Owns the integer register file (2**ADDR_W entries of DATA_W bits) and
// shares its single access port between two requesters: m0 (core datapath)
// and m1 (loader/debug). At most one read or write is accepted per cycle;
// read data (the old value, also for writes) returns one cycle after accept.
// A saturating counter records cycles where both requesters were valid.
//
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   m0, m1          request/response bundles (slave side of the interface)
//   conflict_cnt_o  saturating count of cycles with both requests valid
//
// Build option
//   ARB_ROUND_ROBIN_EN  defined   : contention goes to the requester that
//                                   was not granted last (alternation)
//                       undefined : m0 always wins contention
//   Locking and everything else are identical in both builds.
// ---------------------------------------------------------------------------
module regfile_access_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  regfile_access_arbiter_if.slave m0,
  regfile_access_arbiter_if.slave m1,
  output logic [CNT_W-1:0]        conflict_cnt_o
);

  localparam int NUM_REQ  = 2;
  localparam int NUM_REGS = 1 << ADDR_W;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // Lock ownership: which requester (if any) keeps the grant next cycle.
  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_M0   = 2'd1,
    LOCK_M1   = 2'd2
  } lock_state_e;

  // -------------------------------------------------------------------------
  // Flatten the two interface bundles into indexable arrays
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_we;
  logic [NUM_REQ-1:0] req_lock;
  logic [NUM_REQ-1:0] req_ready;
  logic [ADDR_W-1:0]  req_addr  [NUM_REQ];
  logic [DATA_W-1:0]  req_wdata [NUM_REQ];

  assign req_valid    = {m1.req_valid, m0.req_valid};
  assign req_we       = {m1.req_we,    m0.req_we};
  assign req_lock     = {m1.req_lock,  m0.req_lock};
  assign req_addr[0]  = m0.req_addr;
  assign req_addr[1]  = m1.req_addr;
  assign req_wdata[0] = m0.req_wdata;
  assign req_wdata[1] = m1.req_wdata;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0]  regs_reg [NUM_REGS];
  lock_state_e        lock_state_reg;
  logic               last_grant_reg;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [DATA_W-1:0]  rsp_rdata_reg [NUM_REQ];
  logic [CNT_W-1:0]   conflict_cnt_reg;

  // -------------------------------------------------------------------------
  // Grant selection (combinational from valids and registered state only)
  // -------------------------------------------------------------------------
  logic lock_held;
  logic lock_id;
  logic rr_pick;
  logic grant_valid;
  logic grant_id;

  assign lock_held = (lock_state_reg != LOCK_NONE);
  assign lock_id   = (lock_state_reg == LOCK_M1);
  // The pointer is maintained in both builds; fixed priority simply ignores it.
  assign rr_pick   = ~last_grant_reg;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (lock_held && req_valid[lock_id]) begin
      // Owner keeps the port as long as it keeps requesting.
      grant_valid = 1'b1;
      grant_id    = lock_id;
    end else if (&req_valid) begin
      grant_valid = 1'b1;
      grant_id    = RR_EN ? rr_pick : 1'b0;
    end else if (req_valid[0]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req_valid[1]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // ready is only ever raised for the granted, currently-valid requester, so
  // ready itself is the per-requester accept strobe. It is forced low while
  // reset is asserted.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = rst_ni & grant_valid & (grant_id == 1'(gi)) & req_valid[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Accepted operation
  // -------------------------------------------------------------------------
  logic              accept;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic              acc_lock;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic              both_valid;
  logic              cnt_sat;

  assign accept     = |req_ready;
  assign acc_addr   = req_addr[grant_id];
  assign acc_we     = req_we[grant_id];
  assign acc_lock   = req_lock[grant_id];
  assign acc_wdata  = req_wdata[grant_id];
  // x0 reads as zero regardless of array contents.
  assign rd_data    = (acc_addr == '0) ? '0 : regs_reg[acc_addr];
  assign wr_en      = accept & acc_we & (acc_addr != '0);
  assign both_valid = &req_valid;
  assign cnt_sat    = &conflict_cnt_reg;

  // -------------------------------------------------------------------------
  // Register array. Reset reinitialises entry k to k. The response captures
  // the pre-write value on the same edge, so a write returns the old data and
  // a read in the following cycle sees the new data without any stall.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_reg[k] <= DATA_W'(k);
      end
    end else if (wr_en) begin
      regs_reg[acc_addr] <= acc_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Lock ownership and last-grant pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_state_reg <= LOCK_NONE;
      last_grant_reg <= 1'b1;          // so m0 wins the first contention
    end else if (accept) begin
      last_grant_reg <= grant_id;
      if (acc_lock) begin
        lock_state_reg <= grant_id ? LOCK_M1 : LOCK_M0;
      end else begin
        lock_state_reg <= LOCK_NONE;
      end
    end else begin
      // Nothing accepted means the owner (if any) dropped valid.
      lock_state_reg <= LOCK_NONE;
    end
  end

  // -------------------------------------------------------------------------
  // Responses: one-cycle pulse on the accepting requester, data held until
  // that requester's next accept.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_reg <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        rsp_rdata_reg[k] <= '0;
      end
    end else begin
      rsp_valid_reg <= req_ready;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_ready[k]) begin
          rsp_rdata_reg[k] <= rd_data;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Contention counter, saturating
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_reg <= '0;
    end else if (both_valid && !cnt_sat) begin
      conflict_cnt_reg <= conflict_cnt_reg + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign m0.req_ready    = req_ready[0];
  assign m1.req_ready    = req_ready[1];
  assign m0.rsp_valid    = rsp_valid_reg[0];
  assign m1.rsp_valid    = rsp_valid_reg[1];
  assign m0.rsp_rdata    = rsp_rdata_reg[0];
  assign m1.rsp_rdata    = rsp_rdata_reg[1];
  assign conflict_cnt_o  = conflict_cnt_reg;

endmodule
